input_port_controller: RTL and testbench
========================================

INPUT_PORT_CONTROLLER -- requirements
Module: input_port_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, giving the button stable-time in clk cycles (20 ms at 12.5 MHz).
REQ-002 The block SHALL have parameter CNT_BITS, default 18, giving the debounce counter width; DEBOUNCE_CYCLES SHALL be at most 2^CNT_BITS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port switches_in, input, 8 bits: raw, asynchronous board switches.
REQ-006 The block SHALL have port button_load_in, input, 1 bit: raw, asynchronous, bouncing load button, active-high.
REQ-007 The block SHALL have port input_ack, input, 1 bit: CPU consumed-strobe, one cycle per input read.
REQ-008 The block SHALL have port input_out, output, 32 bits: latched input word for the CPU input register.
REQ-009 The block SHALL have port input_en, output, 1 bit: high while input_out holds an unread word.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, set when an unread word is overwritten.

Function
REQ-011 switches_in and button_load_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 The debounce counter SHALL clear to 0 in every cycle where the synchronized button equals the debounced level.
REQ-013 The debounce counter SHALL increment by 1 in every cycle where the synchronized button differs from the debounced level.
REQ-014 When the debounce counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level SHALL toggle on the next edge and the counter SHALL clear to 0.
REQ-015 A one-cycle load event SHALL be generated on each 0->1 transition of the debounced level; 1->0 transitions SHALL generate no event.
REQ-016 A bounce that returns to the debounced level before DEBOUNCE_CYCLES consecutive differing cycles SHALL produce no event.
REQ-017 The FSM SHALL have two states: EMPTY (input_en=0) and FULL (input_en=1).
REQ-018 In EMPTY, a load event SHALL capture {24'b0, synchronized switches} into input_out and move the FSM to FULL on the same edge.
REQ-019 In EMPTY, input_ack SHALL be ignored and SHALL leave all outputs unchanged.
REQ-020 In FULL with input_ack and no load event, the FSM SHALL move to EMPTY; input_out SHALL hold its last value.
REQ-021 In FULL with a load event and no input_ack, the block SHALL capture the new word, stay FULL, and set overrun.
REQ-022 In FULL with a load event and input_ack in the same cycle, the block SHALL capture the new word, stay FULL, and leave overrun unchanged.
REQ-023 Once set, overrun SHALL clear only on reset.
REQ-024 input_out[31:8] SHALL always be 0.
REQ-025 Latency SHALL be exactly 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles from a clean button rise to input_en high.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 While clr=0 at a rising clk edge, the block SHALL set input_out=0, input_en=0, overrun=0, FSM=EMPTY, debounced level=0, debounce counter=0, and all synchronizer flops=0.
REQ-028 clr=0 asserted mid-debounce or while FULL SHALL discard the pending word and the count, with no event generated after release.
REQ-029 A button held high through reset release SHALL produce exactly one load event, DEBOUNCE_CYCLES+2 cycles after release.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 Clean press: switches=8'hA5, button held high from cycle 0 -> input_en rises at cycle 7 with input_out=32'h000000A5, and overrun stays 0.
REQ-031 Bounce: button toggles 1,0,1,0 on successive cycles, then stays high -> exactly one event, occurring 7 cycles after the final rise.
REQ-032 Consume: word 8'h3C in FULL, then a 1-cycle input_ack -> input_en=0 on the next edge, input_out stays 32'h0000003C, and a second input_ack has no effect.
REQ-033 Overrun: press with 8'h11, release, press with 8'h22, with no ack -> input_out=32'h00000022, input_en=1, overrun=1.
REQ-034 Simultaneous: the second load event coincides with input_ack -> input_out holds the new value, input_en=1, overrun=0.
REQ-035 Reset mid-operation: clr=0 for 1 cycle while FULL with overrun=1 -> all outputs 0 on the next edge, and no event while the button stays low.

Source files
------------

// File: rtl/input_port_controller.sv
// ---------------------------------------------------------------------------
// input_port_controller
//
// Turns the board's raw switches and bouncing "load" push-button into a
// one-word input register for the CPU. Pressing the button captures the
// switch byte. The word stays valid until the CPU acknowledges it.
// Overwriting an unread word raises a sticky overrun flag.
//
// Parameters
//   DEBOUNCE_CYCLES : clk cycles the button must stay at a new level before
//                     that level is accepted (must be <= 2**CNT_BITS)
//   CNT_BITS        : width of the debounce counter
//
// Ports
//   clk            in   1  single clock, everything updates on its rising edge
//   clr            in   1  synchronous active-low reset
//   switches_in    in   8  raw asynchronous board switches
//   button_load_in in   1  raw asynchronous bouncing load button, active-high
//   input_ack      in   1  CPU consumed-strobe, one cycle per read
//   input_out      out 32  latched input word, upper 24 bits always zero
//   input_en       out  1  high while input_out holds an unread word
//   overrun        out  1  sticky, set when an unread word is overwritten
// ---------------------------------------------------------------------------
module input_port_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BITS        = 18
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  switches_in,
    input  logic        button_load_in,
    input  logic        input_ack,
    output logic [31:0] input_out,
    output logic        input_en,
    output logic        overrun
);

    // Counter value at which the differing button level is accepted.
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Synchronizer stages
    logic [7:0]          sw_meta_r;
    logic [7:0]          sw_sync_r;
    logic                btn_meta_r;
    logic                btn_sync_r;

    // Debouncer
    logic                db_level_r;
    logic                db_level_d_r;
    logic [CNT_BITS-1:0] db_cnt_r;
    logic                db_level_s;
    logic [CNT_BITS-1:0] db_cnt_s;
    logic                load_evt_s;

    // Input register FSM and outputs
    state_t              state_r;
    state_t              state_s;
    logic [7:0]          word_r;
    logic [7:0]          word_s;
    logic                input_en_r;
    logic                input_en_s;
    logic                overrun_r;
    logic                overrun_s;

    // Two-flop synchronizers for the asynchronous switch and button inputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sw_meta_r  <= 8'h00;
            sw_sync_r  <= 8'h00;
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            sw_meta_r  <= switches_in;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= button_load_in;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce next-state: count consecutive cycles the button disagrees
    // with the accepted level; any agreeing cycle restarts the count.
    always_comb begin
        db_level_s = db_level_r;
        db_cnt_s   = db_cnt_r;
        if (btn_sync_r == db_level_r) begin
            db_cnt_s = {CNT_BITS{1'b0}};
        end else if (db_cnt_r == CNT_LAST) begin
            db_level_s = ~db_level_r;
            db_cnt_s   = {CNT_BITS{1'b0}};
        end else begin
            db_cnt_s = db_cnt_r + CNT_BITS'(1);
        end
    end

    // Debounce state. db_level_d_r delays the level by one cycle so a rise
    // appears as a single-cycle event from registered signals only.
    always_ff @(posedge clk) begin
        if (!clr) begin
            db_level_r   <= 1'b0;
            db_level_d_r <= 1'b0;
            db_cnt_r     <= {CNT_BITS{1'b0}};
        end else begin
            db_level_r   <= db_level_s;
            db_level_d_r <= db_level_r;
            db_cnt_r     <= db_cnt_s;
        end
    end

    // Only the press (0->1) of the debounced button loads a word.
    assign load_evt_s = db_level_r & ~db_level_d_r;

    // FSM next-state and output next-values. A load always wins over an
    // acknowledge; a load into a full register without a matching ack
    // means the CPU never saw the old word.
    always_comb begin
        state_s   = state_r;
        word_s    = word_r;
        overrun_s = overrun_r;
        case (state_r)
            ST_EMPTY: begin
                if (load_evt_s) begin
                    word_s  = sw_sync_r;
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (load_evt_s) begin
                    word_s  = sw_sync_r;
                    state_s = ST_FULL;
                    if (!input_ack) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                end else if (input_ack) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        input_en_s = (state_s == ST_FULL);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r    <= ST_EMPTY;
            word_r     <= 8'h00;
            input_en_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_r     <= word_s;
            input_en_r <= input_en_s;
            overrun_r  <= overrun_s;
        end
    end

    assign input_out = {24'h000000, word_r};
    assign input_en  = input_en_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_input_port_controller.sv
// ---------------------------------------------------------------------------
// Testbench for input_port_controller (DEBOUNCE_CYCLES = 4).
// Directed scenarios check the documented example outcomes against constants.
// A randomized phase then runs. Every cycle the DUT outputs are compared
// against a behavioural model. That model tracks the raw input history, a
// run-length of disagreeing cycles, and the register/overrun rules.
// ---------------------------------------------------------------------------
module tb_input_port_controller;

    localparam int DEB = 4;

    logic        clk;
    logic        clr;
    logic [7:0]  switches_in;
    logic        button_load_in;
    logic        input_ack;
    logic [31:0] input_out;
    logic        input_en;
    logic        overrun;

    int n_vec;
    int n_err;

    // Reference model state
    bit [7:0]  m_sw_q[$];
    bit        m_btn_q[$];
    int        m_run;
    bit        m_level;
    bit        m_evt_pend;
    bit [31:0] m_out;
    bit        m_en;
    bit        m_ovr;

    input_port_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_BITS(3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .switches_in(switches_in),
        .button_load_in(button_load_in),
        .input_ack(input_ack),
        .input_out(input_out),
        .input_en(input_en),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: raw inputs reach the logic two edges later; the accepted button
    // level flips after DEB consecutive disagreeing edges; a rise produces a
    // load that takes effect on the following edge.
    task automatic model_edge(input bit c, input bit [7:0] sw, input bit b, input bit a);
        bit       evt;
        bit       sb;
        bit [7:0] ssw;
        if (!c) begin
            m_sw_q     = '{8'h00, 8'h00};
            m_btn_q    = '{1'b0, 1'b0};
            m_run      = 0;
            m_level    = 1'b0;
            m_evt_pend = 1'b0;
            m_out      = 32'h0;
            m_en       = 1'b0;
            m_ovr      = 1'b0;
        end else begin
            evt = m_evt_pend;
            sb  = m_btn_q[0];
            ssw = m_sw_q[0];
            if (evt) begin
                if (m_en && !a) m_ovr = 1'b1;
                m_out = {24'h0, ssw};
                m_en  = 1'b1;
            end else if (m_en && a) begin
                m_en = 1'b0;
            end
            m_evt_pend = 1'b0;
            if (sb != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEB) begin
                    m_level    = !m_level;
                    m_run      = 0;
                    m_evt_pend = m_level;
                end
            end else begin
                m_run = 0;
            end
            void'(m_sw_q.pop_front());
            void'(m_btn_q.pop_front());
            m_sw_q.push_back(sw);
            m_btn_q.push_back(b);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic c, input logic [7:0] sw, input logic b, input logic a);
        clr            = c;
        switches_in    = sw;
        button_load_in = b;
        input_ack      = a;
        @(posedge clk);
        model_edge(c, sw, b, a);
        #1;
        check_eq("model_out", input_out, m_out);
        check_eq("model_en", {31'b0, input_en}, {31'b0, m_en});
        check_eq("model_ovr", {31'b0, overrun}, {31'b0, m_ovr});
    endtask

    task automatic run(input int n, input logic c, input logic [7:0] sw, input logic b, input logic a);
        for (int i = 0; i < n; i++) step(c, sw, b, a);
    endtask

    initial begin
        bit       rb;
        int       hold;
        n_vec          = 0;
        n_err          = 0;
        clr            = 1'b0;
        switches_in    = 8'h00;
        button_load_in = 1'b0;
        input_ack      = 1'b0;
        m_sw_q         = '{8'h00, 8'h00};
        m_btn_q        = '{1'b0, 1'b0};

        // Reset state
        run(3, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rst_out", input_out, 32'h0);
        check_eq("rst_en", {31'b0, input_en}, 32'h0);
        check_eq("rst_ovr", {31'b0, overrun}, 32'h0);

        // Clean press: visible exactly at cycle 7
        run(6, 1'b1, 8'hA5, 1'b1, 1'b0);
        check_eq("press_c6_en", {31'b0, input_en}, 32'h0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        check_eq("press_c7_en", {31'b0, input_en}, 32'h1);
        check_eq("press_c7_out", input_out, 32'h000000A5);
        check_eq("press_c7_ovr", {31'b0, overrun}, 32'h0);
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        check_eq("ack_a5_en", {31'b0, input_en}, 32'h0);
        run(10, 1'b1, 8'h00, 1'b0, 1'b0);

        // Consume, then a second ack while empty
        run(7, 1'b1, 8'h3C, 1'b1, 1'b0);
        check_eq("load_3c_en", {31'b0, input_en}, 32'h1);
        check_eq("load_3c_out", input_out, 32'h0000003C);
        step(1'b1, 8'h3C, 1'b1, 1'b1);
        check_eq("consume_en", {31'b0, input_en}, 32'h0);
        check_eq("consume_out", input_out, 32'h0000003C);
        step(1'b1, 8'h3C, 1'b1, 1'b1);
        check_eq("ack2_en", {31'b0, input_en}, 32'h0);
        check_eq("ack2_out", input_out, 32'h0000003C);
        check_eq("ack2_ovr", {31'b0, overrun}, 32'h0);
        run(10, 1'b1, 8'h00, 1'b0, 1'b0);

        // Bounce 1,0,1,0 then steady high: one event 7 cycles after final rise
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        run(6, 1'b1, 8'h5A, 1'b1, 1'b0);
        check_eq("bounce_c6_en", {31'b0, input_en}, 32'h0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check_eq("bounce_c7_en", {31'b0, input_en}, 32'h1);
        check_eq("bounce_c7_out", input_out, 32'h0000005A);
        check_eq("bounce_ovr", {31'b0, overrun}, 32'h0);
        run(10, 1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1);
        check_eq("ack_5a_en", {31'b0, input_en}, 32'h0);

        // Overrun: two loads without an ack
        run(7, 1'b1, 8'h11, 1'b1, 1'b0);
        check_eq("ovr_first_ovr", {31'b0, overrun}, 32'h0);
        run(10, 1'b1, 8'h00, 1'b0, 1'b0);
        run(7, 1'b1, 8'h22, 1'b1, 1'b0);
        check_eq("ovr_out", input_out, 32'h00000022);
        check_eq("ovr_en", {31'b0, input_en}, 32'h1);
        check_eq("ovr_flag", {31'b0, overrun}, 32'h1);

        // Reset while full with overrun set
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("midrst_out", input_out, 32'h0);
        check_eq("midrst_en", {31'b0, input_en}, 32'h0);
        check_eq("midrst_ovr", {31'b0, overrun}, 32'h0);
        run(20, 1'b1, 8'h00, 1'b0, 1'b0);
        check_eq("postrst_en", {31'b0, input_en}, 32'h0);

        // Load coincident with ack: no overrun
        run(7, 1'b1, 8'h11, 1'b1, 1'b0);
        run(10, 1'b1, 8'h00, 1'b0, 1'b0);
        run(6, 1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b1);
        check_eq("simul_out", input_out, 32'h00000022);
        check_eq("simul_en", {31'b0, input_en}, 32'h1);
        check_eq("simul_ovr", {31'b0, overrun}, 32'h0);

        // Reset mid-debounce discards the pending press
        run(10, 1'b1, 8'h00, 1'b0, 1'b0);
        run(4, 1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b0, 8'h33, 1'b0, 1'b0);
        run(15, 1'b1, 8'h33, 1'b0, 1'b0);
        check_eq("dbrst_en", {31'b0, input_en}, 32'h0);
        check_eq("dbrst_out", input_out, 32'h0);

        // Button held through reset release: one event, visible 7 cycles after
        run(2, 1'b0, 8'h44, 1'b1, 1'b0);
        run(6, 1'b1, 8'h44, 1'b1, 1'b0);
        check_eq("hold_c6_en", {31'b0, input_en}, 32'h0);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        check_eq("hold_c7_en", {31'b0, input_en}, 32'h1);
        check_eq("hold_c7_out", input_out, 32'h00000044);
        run(20, 1'b1, 8'h44, 1'b1, 1'b0);
        check_eq("hold_single_ovr", {31'b0, overrun}, 32'h0);

        // Randomized phase against the model
        rb   = 1'b0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                rb   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold = hold - 1;
            step(($urandom_range(0, 299) != 0), 8'($urandom), rb,
                 ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
